// File: rtl/cmult_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin complex-multiplier arbiter.
package cmult_rr_arbiter_pkg;

    localparam int unsigned CMULT_MAX_REQ = 8;
    localparam int unsigned CMULT_IDX_W   = 3;

    typedef logic [CMULT_IDX_W-1:0] t_cmult_idx;

    typedef struct packed {
        logic       found;
        t_cmult_idx idx;
    } t_rr_pick;

    // First eligible index at or above ptr, wrapping modulo n_req.
    function automatic t_rr_pick f_rr_pick(
        input logic [CMULT_MAX_REQ-1:0] eligible,
        input t_cmult_idx               ptr,
        input int unsigned              n_req
    );
        t_rr_pick    pick;
        int unsigned pos;
        pick.found = 1'b0;
        pick.idx   = '0;
        for (int unsigned off = 0; off < CMULT_MAX_REQ; off++) begin
            pos = (32'(ptr) + off) % n_req;
            if ((off < n_req) && !pick.found && eligible[pos[CMULT_IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = t_cmult_idx'(pos);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cmult_rr_arbiter_pipe.sv
// Pipelined full-precision complex multiplier; the one-hot owner and tag
// travel with the data so the last stage is directly the result interface.
module cmult_rr_arbiter_pipe #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int LAT    = 3,
    parameter int TAG_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    in_hot,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [DATA_W-1:0]   in_ai,
    input  logic [DATA_W-1:0]   in_aq,
    input  logic [DATA_W-1:0]   in_bi,
    input  logic [DATA_W-1:0]   in_bq,
    input  logic                in_conj,
    output logic [N_REQ-1:0]    out_hot,
    output logic [TAG_W-1:0]    out_tag,
    output logic [2*DATA_W:0]   out_i,
    output logic [2*DATA_W:0]   out_q
);

    localparam int RES_W = 2*DATA_W+1;

    logic signed [RES_W-1:0] ai_s, aq_s, bi_s, bq_s;
    logic signed [RES_W-1:0] pii_s, pqq_s, pqi_s, piq_s;
    logic signed [RES_W-1:0] re_s, im_s;

    logic [N_REQ-1:0] hot_r [LAT];
    logic [TAG_W-1:0] tag_r [LAT];
    logic [RES_W-1:0] re_r  [LAT];
    logic [RES_W-1:0] im_r  [LAT];

    // Sign-extend to the result width so every product and sum is exact.
    always_comb begin
        ai_s  = {{(DATA_W+1){in_ai[DATA_W-1]}}, in_ai};
        aq_s  = {{(DATA_W+1){in_aq[DATA_W-1]}}, in_aq};
        bi_s  = {{(DATA_W+1){in_bi[DATA_W-1]}}, in_bi};
        bq_s  = {{(DATA_W+1){in_bq[DATA_W-1]}}, in_bq};
        pii_s = ai_s * bi_s;
        pqq_s = aq_s * bq_s;
        pqi_s = aq_s * bi_s;
        piq_s = ai_s * bq_s;
        if (in_conj) begin
            re_s = pii_s + pqq_s;
            im_s = pqi_s - piq_s;
        end else begin
            re_s = pii_s - pqq_s;
            im_s = pqi_s + piq_s;
        end
    end

    // Delay line: valids always advance, payload only loads behind a valid so
    // the output holds the last result between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                hot_r[k] <= '0;
                tag_r[k] <= '0;
                re_r[k]  <= '0;
                im_r[k]  <= '0;
            end
        end else begin
            hot_r[0] <= in_hot;
            if (|in_hot) begin
                tag_r[0] <= in_tag;
                re_r[0]  <= re_s;
                im_r[0]  <= im_s;
            end
            for (int k = 1; k < LAT; k++) begin
                hot_r[k] <= hot_r[k-1];
                if (|hot_r[k-1]) begin
                    tag_r[k] <= tag_r[k-1];
                    re_r[k]  <= re_r[k-1];
                    im_r[k]  <= im_r[k-1];
                end
            end
        end
    end

    assign out_hot = hot_r[LAT-1];
    assign out_tag = tag_r[LAT-1];
    assign out_i   = re_r[LAT-1];
    assign out_q   = im_r[LAT-1];

endmodule

// File: rtl/cmult_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined complex multiplier between
// N_REQ requesters; results return tagged and one-hot MULT_LAT cycles later.
module cmult_rr_arbiter
    import cmult_rr_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 16,
    parameter int MULT_LAT = 3,
    parameter int TAG_W    = 3
) (
    input  logic                    iclk,
    input  logic                    iresetn,
    input  logic [N_REQ-1:0]        ivalid,
    input  logic [N_REQ*DATA_W-1:0] ia_i,
    input  logic [N_REQ*DATA_W-1:0] ia_q,
    input  logic [N_REQ*DATA_W-1:0] ib_i,
    input  logic [N_REQ*DATA_W-1:0] ib_q,
    input  logic [N_REQ-1:0]        iconj,
    input  logic [N_REQ-1:0]        iena,
    output logic [N_REQ-1:0]        ogrant,
    output logic [N_REQ-1:0]        ovalid,
    output logic [TAG_W-1:0]        otag,
    output logic [2*DATA_W:0]       oi,
    output logic [2*DATA_W:0]       oq,
    output logic [TAG_W:0]          oinflight
);

    logic [N_REQ-1:0]  eligible_s;
    logic [N_REQ-1:0]  grant_s;
    logic [TAG_W-1:0]  grant_tag_s;
    t_rr_pick          pick_s;
    t_cmult_idx        ptr_r;
    t_cmult_idx        ptr_next_s;
    logic [DATA_W-1:0] ai_s, aq_s, bi_s, bq_s;
    logic              conj_s;
    logic [TAG_W:0]    inflight_r;

    // Round-robin pick; grant is forced low while reset is asserted.
    always_comb begin
        eligible_s  = ivalid & iena;
        pick_s      = f_rr_pick(CMULT_MAX_REQ'(eligible_s), ptr_r, N_REQ);
        grant_s     = '0;
        grant_tag_s = '0;
        if (pick_s.found && iresetn) begin
            grant_s     = N_REQ'(1'b1) << pick_s.idx;
            grant_tag_s = TAG_W'(pick_s.idx);
        end else begin
            grant_s     = '0;
            grant_tag_s = '0;
        end
        if (pick_s.idx == t_cmult_idx'(N_REQ-1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_s.idx + t_cmult_idx'(1);
        end
    end

    // AND-OR operand mux driven by the one-hot grant.
    always_comb begin
        ai_s   = '0;
        aq_s   = '0;
        bi_s   = '0;
        bq_s   = '0;
        conj_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            ai_s   = ai_s | (ia_i[k*DATA_W +: DATA_W] & {DATA_W{grant_s[k]}});
            aq_s   = aq_s | (ia_q[k*DATA_W +: DATA_W] & {DATA_W{grant_s[k]}});
            bi_s   = bi_s | (ib_i[k*DATA_W +: DATA_W] & {DATA_W{grant_s[k]}});
            bq_s   = bq_s | (ib_q[k*DATA_W +: DATA_W] & {DATA_W{grant_s[k]}});
            conj_s = conj_s | (iconj[k] & grant_s[k]);
        end
    end

    // Pointer moves just past the winner; idle cycles leave it alone.
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            ptr_r <= '0;
        end else if (pick_s.found) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // In-flight count: a result stops counting once its ovalid cycle is over.
    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            inflight_r <= '0;
        end else begin
            case ({|grant_s, |ovalid})
                2'b10:   inflight_r <= inflight_r + (TAG_W+1)'(1'b1);
                2'b01:   inflight_r <= inflight_r - (TAG_W+1)'(1'b1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    cmult_rr_arbiter_pipe #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .LAT    (MULT_LAT),
        .TAG_W  (TAG_W)
    ) u_pipe (
        .clk     (iclk),
        .rst_n   (iresetn),
        .in_hot  (grant_s),
        .in_tag  (grant_tag_s),
        .in_ai   (ai_s),
        .in_aq   (aq_s),
        .in_bi   (bi_s),
        .in_bq   (bq_s),
        .in_conj (conj_s),
        .out_hot (ovalid),
        .out_tag (otag),
        .out_i   (oi),
        .out_q   (oq)
    );

    assign ogrant    = grant_s;
    assign oinflight = inflight_r;

endmodule

// File: doc/cmult_rr_arbiter.md
Name: cmult_rr_arbiter

Overview:
- Shares one pipelined complex multiplier between N_REQ requesters, e.g. NCO mixer, correlator and AGC detector.
- Each requester presents operands a, b and a conj flag; the block grants one requester per cycle (round-robin) and pushes its operands into the multiplier.
- Each result is tagged with the requester index and returned `MULT_LAT` cycles later as a one-hot valid.
- Sits between the modem DSP requesters and the single DSP-slice complex multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 16, signed width of each I/Q operand component.
- MULT_LAT, 3, multiplier pipeline depth in cycles (1..6).
- TAG_W, 3, width of requester index (≥ clog2(N_REQ)).

Ports:
- iclk  in  1  clock.
- iresetn  in  1  asynchronous active-low reset.
- ivalid  in  N_REQ  per-requester request valid.
- ia_i  in  N_REQ*DATA_W  operand a, I part; slot k = bits [k*DATA_W +: DATA_W].
- ia_q  in  N_REQ*DATA_W  operand a, Q part.
- ib_i  in  N_REQ*DATA_W  operand b, I part.
- ib_q  in  N_REQ*DATA_W  operand b, Q part.
- iconj  in  N_REQ  1 = multiply a by conj(b).
- iena  in  N_REQ  requester enable mask; a masked requester is never granted.
- ogrant  out  N_REQ  one-hot; request k consumed this cycle (combinational from ivalid/iena/pointer).
- ovalid  out  N_REQ  one-hot result valid, registered.
- otag  out  TAG_W  index of result owner.
- oi  out  2*DATA_W+1  result I, signed.
- oq  out  2*DATA_W+1  result Q, signed.
- oinflight  out  TAG_W+1  number of operations in the pipeline.

Behaviour:
- Reset (iresetn=0, asynchronous):
  - pointer=0;
  - all pipeline valid bits cleared;
  - ovalid=0, otag=0, oi=0, oq=0, oinflight=0.
  - ogrant=0 while reset is asserted.
  - Reset mid-operation discards all in-flight results; no ovalid after release for operations granted before reset.
- Arbitration, each cycle:
  - eligible = ivalid & iena.
  - Search from pointer upward, wrapping modulo N_REQ; the first eligible index k wins.
  - ogrant[k]=1, all other bits 0.
  - If nothing is eligible: ogrant=0 and pointer unchanged.
- Pointer update: on a grant to k, pointer <= (k+1) mod N_REQ on the next clock edge.
- Handshake:
  - A requester holds ivalid and its operands stable until it sees its ogrant bit at a clock edge.
  - The block never stalls; at most one op is issued per cycle.
  - No output backpressure; receivers must accept ovalid immediately.
- Issue: the granted operands, conj flag, tag and valid=1 enter stage 1 of the multiplier on the grant edge.
- Latency: op granted at edge t has ovalid[k]=1, otag=k, oi/oq valid in the cycle after edge t+MULT_LAT-1, i.e. exactly MULT_LAT cycles after grant.
- Throughput: back-to-back grants give back-to-back results in grant order.
- Arithmetic:
  - Operands are sign-extended to 2*DATA_W+1 bits.
  - conj=0: I = ai*bi − aq*bq, Q = aq*bi + ai*bq.
  - conj=1: I = ai*bi + aq*bq, Q = aq*bi − ai*bq.
  - Full precision; no rounding, no saturation. The width is sufficient for (−2^(DATA_W−1))² terms without overflow.
- Output values when ovalid=0: oi/oq/otag hold their last value (no requirement on their content).
- oinflight:
  - Increments on a grant, decrements when a result exits.
  - Simultaneous grant and exit leaves it unchanged.
  - Range 0..MULT_LAT.
- iena change: takes effect in the same cycle. Deasserting iena for a requester with ops in flight does not cancel those results.
- Wrap-around: with all requesters continuously valid, grant sequence is 0,1,..,N_REQ−1,0,...

Decomposition:
- pkg_modem: t_iq (existing) for operand pairs.
- pkg_modem: new t_cmult_tag (logic [TAG_W−1:0]) and t_cmult_op struct {t_iq a; t_iq b; bit conj; t_cmult_tag tag; bit valid}.
- Reference model uses pkg_modem_math f_complex_mult.
- Sub-module: cmult_pipe
  - Pure MULT_LAT-deep pipelined complex multiplier.
  - Carries the conj/tag/valid sideband alongside the data.
- The arbiter, pointer and oinflight logic stay in the top level.

Test Plan:
1. Single request:
   - Stimulus: reset, then ivalid=0001, a=(3,4), b=(1,−2), conj=0.
   - Required: ogrant=0001 same cycle; 3 cycles later ovalid=0001, otag=0, oi=11, oq=−2.
2. Conjugate:
   - Stimulus: requester 2, a=(3,4), b=(1,−2), conj=1.
   - Required: ovalid=0100, otag=2, oi=−5, oq=10.
3. Fairness:
   - Stimulus: all four valid continuously for 8 cycles, iena=1111.
   - Required: grants 0,1,2,3,0,1,2,3; results in the same order; oinflight saturates at 3.
4. Masking and skip:
   - Stimulus: ivalid=1010, iena=0010, pointer=0.
   - Required: only requester 1 is granted, repeatedly; requester 3 is never granted.
5. Extreme values:
   - Stimulus: a=b=(−32768,−32768), conj=0.
   - Required: oi=0, oq=2147483648 (33-bit signed, no overflow).
   - Stimulus: conj=1 with the same operands.
   - Required: oi=2147483648, oq=0.
6. Mid-operation reset:
   - Stimulus: grant 2 ops, assert iresetn=0 one cycle later, release.
   - Required: no ovalid pulses afterwards, oinflight=0, next grant goes to requester 0.
